// File: rtl/rx_iq_scheduler_pkg.sv
// Shared widths, pairing-state encoding and frame layout for the RX IQ scheduler.
// The frame packs RX1 I/Q above RX2 I/Q, 96 bits in total.
package rx_iq_scheduler_pkg;

    localparam int IQ_W       = 24;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = 4;
    localparam int FRAME_W    = 4 * IQ_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HAVE1 = 2'd1,
        HAVE2 = 2'd2
    } pair_state_t;

    typedef struct packed {
        logic [IQ_W-1:0] rx1_i;
        logic [IQ_W-1:0] rx1_q;
        logic [IQ_W-1:0] rx2_i;
        logic [IQ_W-1:0] rx2_q;
    } iq_frame_t;

    function automatic iq_frame_t make_frame(input logic [IQ_W-1:0] i1, input logic [IQ_W-1:0] q1,
                                             input logic [IQ_W-1:0] i2, input logic [IQ_W-1:0] q2);
        iq_frame_t f;
        f.rx1_i = i1;
        f.rx1_q = q1;
        f.rx2_i = i2;
        f.rx2_q = q2;
        return f;
    endfunction

endpackage

// File: rtl/rx_iq_scheduler_if.sv
// Bus-side read port of the scheduler: pop request, popped frame, status and sticky flags.
interface rx_iq_scheduler_if;
    import rx_iq_scheduler_pkg::*;

    logic                IQ_RX_READ_REQ;
    logic                flags_clear;
    logic [IQ_W-1:0]     rd_rx1_i;
    logic [IQ_W-1:0]     rd_rx1_q;
    logic [IQ_W-1:0]     rd_rx2_i;
    logic [IQ_W-1:0]     rd_rx2_q;
    logic                rd_valid;
    logic                in_empty;
    logic                iq_overrun;
    logic                iq_underrun;
    logic                pair_slip;
    logic [FIFO_AW:0]    fill_level;

    modport master (
        output IQ_RX_READ_REQ, flags_clear,
        input  rd_rx1_i, rd_rx1_q, rd_rx2_i, rd_rx2_q, rd_valid,
        input  in_empty, iq_overrun, iq_underrun, pair_slip, fill_level
    );

    modport slave (
        input  IQ_RX_READ_REQ, flags_clear,
        output rd_rx1_i, rd_rx1_q, rd_rx2_i, rd_rx2_q, rd_valid,
        output in_empty, iq_overrun, iq_underrun, pair_slip, fill_level
    );

endinterface

// File: rtl/rx_iq_scheduler_fifo.sv
// Single-clock 16-deep frame FIFO; a write while full is accepted only alongside a read,
// and a read while empty is ignored even if a write arrives in the same cycle.
module iq_frame_fifo
    import rx_iq_scheduler_pkg::*;
(
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             wr_en,
    input  iq_frame_t        wr_data,
    input  logic             rd_en,
    output iq_frame_t        rd_data,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] count
);

    iq_frame_t          mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               wr_ok;
    logic               rd_ok;

    assign full    = (count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_en);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // 4-bit pointers wrap 15->0 naturally
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (FIFO_AW+1)'(wr_ok) - (FIFO_AW+1)'(rd_ok);
        end
    end

endmodule

// File: rtl/rx_iq_scheduler.sv
// Pairs RX1/RX2 decimator samples into frames, queues them in iq_frame_fifo and
// serves bus pops with sticky overrun/underrun/slip flags.
module rx_iq_scheduler
    import rx_iq_scheduler_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   reset_n,
    input  logic                   rx1_enable,
    input  logic                   rx2_enable,
    input  logic signed [IQ_W-1:0] RX1_I,
    input  logic signed [IQ_W-1:0] RX1_Q,
    input  logic signed [IQ_W-1:0] RX2_I,
    input  logic signed [IQ_W-1:0] RX2_Q,
    input  logic                   rx1_valid,
    input  logic                   rx2_valid,
    rx_iq_scheduler_if.slave       bus
);

    pair_state_t      state, state_n, cur;
    logic [IQ_W-1:0]  h1_i, h1_q, h2_i, h2_q;
    logic [IQ_W-1:0]  h1_i_n, h1_q_n, h2_i_n, h2_q_n;
    logic             e1_q, e2_q, en_change;
    logic             push, slip_evt, pop_ok, overrun_evt, underrun_evt;
    iq_frame_t        push_frame, head;
    logic             full, empty;
    logic [FIFO_AW:0] count;

    assign en_change    = (rx1_enable != e1_q) || (rx2_enable != e2_q);
    assign pop_ok       = bus.IQ_RX_READ_REQ && !empty;
    assign overrun_evt  = push && full && !bus.IQ_RX_READ_REQ;
    assign underrun_evt = bus.IQ_RX_READ_REQ && empty;
    assign bus.fill_level = count;
    assign bus.in_empty   = empty;

    always_comb begin
        state_n    = state;
        h1_i_n     = h1_i;
        h1_q_n     = h1_q;
        h2_i_n     = h2_i;
        h2_q_n     = h2_q;
        push       = 1'b0;
        push_frame = '0;
        slip_evt   = 1'b0;
        cur        = state;
        // An enable edge drops any half-built pair before this cycle's strobes are handled
        if (en_change) begin
            cur    = IDLE;
            h1_i_n = '0;
            h1_q_n = '0;
            h2_i_n = '0;
            h2_q_n = '0;
        end
        state_n = cur;
        case ({rx1_enable, rx2_enable})
            2'b10: begin
                state_n = IDLE;
                if (rx1_valid) begin
                    push       = 1'b1;
                    push_frame = make_frame(RX1_I, RX1_Q, '0, '0);
                end
            end
            2'b01: begin
                state_n = IDLE;
                if (rx2_valid) begin
                    push       = 1'b1;
                    push_frame = make_frame('0, '0, RX2_I, RX2_Q);
                end
            end
            2'b11: begin
                if (rx1_valid && rx2_valid) begin
                    push       = 1'b1;
                    push_frame = make_frame(RX1_I, RX1_Q, RX2_I, RX2_Q);
                    slip_evt   = (cur != IDLE);
                    state_n    = IDLE;
                end else if (rx1_valid) begin
                    if (cur == HAVE2) begin
                        push       = 1'b1;
                        push_frame = make_frame(RX1_I, RX1_Q, h2_i_n, h2_q_n);
                        state_n    = IDLE;
                    end else begin
                        slip_evt = (cur == HAVE1);
                        h1_i_n   = RX1_I;
                        h1_q_n   = RX1_Q;
                        state_n  = HAVE1;
                    end
                end else if (rx2_valid) begin
                    if (cur == HAVE1) begin
                        push       = 1'b1;
                        push_frame = make_frame(h1_i_n, h1_q_n, RX2_I, RX2_Q);
                        state_n    = IDLE;
                    end else begin
                        slip_evt = (cur == HAVE2);
                        h2_i_n   = RX2_I;
                        h2_q_n   = RX2_Q;
                        state_n  = HAVE2;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    iq_frame_fifo u_fifo (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_data (push_frame),
        .rd_en   (bus.IQ_RX_READ_REQ),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // A new flag event in the same cycle as flags_clear keeps the flag set
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state           <= IDLE;
            h1_i            <= '0;
            h1_q            <= '0;
            h2_i            <= '0;
            h2_q            <= '0;
            e1_q            <= 1'b0;
            e2_q            <= 1'b0;
            bus.rd_rx1_i    <= '0;
            bus.rd_rx1_q    <= '0;
            bus.rd_rx2_i    <= '0;
            bus.rd_rx2_q    <= '0;
            bus.rd_valid    <= 1'b0;
            bus.iq_overrun  <= 1'b0;
            bus.iq_underrun <= 1'b0;
            bus.pair_slip   <= 1'b0;
        end else begin
            state           <= state_n;
            h1_i            <= h1_i_n;
            h1_q            <= h1_q_n;
            h2_i            <= h2_i_n;
            h2_q            <= h2_q_n;
            e1_q            <= rx1_enable;
            e2_q            <= rx2_enable;
            bus.rd_valid    <= pop_ok;
            if (pop_ok) begin
                bus.rd_rx1_i <= head.rx1_i;
                bus.rd_rx1_q <= head.rx1_q;
                bus.rd_rx2_i <= head.rx2_i;
                bus.rd_rx2_q <= head.rx2_q;
            end
            bus.iq_overrun  <= (bus.iq_overrun  && !bus.flags_clear) || overrun_evt;
            bus.iq_underrun <= (bus.iq_underrun && !bus.flags_clear) || underrun_evt;
            bus.pair_slip   <= (bus.pair_slip   && !bus.flags_clear) || slip_evt;
        end
    end

endmodule

// File: tb/tb_rx_iq_scheduler.sv
// Self-checking bench for rx_iq_scheduler: directed scenarios plus a randomized run
// against a queue-based reference model of the pairing and FIFO rules.
module tb_rx_iq_scheduler;
    import rx_iq_scheduler_pkg::*;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic              reset_n;
    logic              rx1_enable, rx2_enable, rx1_valid, rx2_valid;
    logic signed [23:0] RX1_I, RX1_Q, RX2_I, RX2_Q;

    rx_iq_scheduler_if bus();

    rx_iq_scheduler dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .rx1_enable (rx1_enable),
        .rx2_enable (rx2_enable),
        .RX1_I      (RX1_I),
        .RX1_Q      (RX1_Q),
        .RX2_I      (RX2_I),
        .RX2_Q      (RX2_Q),
        .rx1_valid  (rx1_valid),
        .rx2_valid  (rx2_valid),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [95:0] m_q[$];
    int          m_pend;
    logic [23:0] m_hi, m_hq;
    logic        m_ovr, m_und, m_slip, m_rdv, m_e1p, m_e2p;
    logic [95:0] m_rd;

    function automatic logic [95:0] rd_frame();
        return {bus.rd_rx1_i, bus.rd_rx1_q, bus.rd_rx2_i, bus.rd_rx2_q};
    endfunction

    task automatic model_update();
        logic [95:0] f;
        bit push, slip, pop_ok, und, ovr;
        if (!reset_n) begin
            m_q.delete();
            m_pend = 0; m_hi = '0; m_hq = '0;
            m_ovr = 0; m_und = 0; m_slip = 0; m_rdv = 0; m_rd = '0;
            m_e1p = 0; m_e2p = 0;
            return;
        end
        push = 0; slip = 0; f = '0;
        if (rx1_enable != m_e1p || rx2_enable != m_e2p) m_pend = 0;
        if (rx1_enable && !rx2_enable) begin
            m_pend = 0;
            if (rx1_valid) begin push = 1; f = {RX1_I, RX1_Q, 48'd0}; end
        end else if (!rx1_enable && rx2_enable) begin
            m_pend = 0;
            if (rx2_valid) begin push = 1; f = {48'd0, RX2_I, RX2_Q}; end
        end else if (rx1_enable && rx2_enable) begin
            if (rx1_valid && rx2_valid) begin
                push = 1; f = {RX1_I, RX1_Q, RX2_I, RX2_Q};
                slip = (m_pend != 0); m_pend = 0;
            end else if (rx1_valid) begin
                if (m_pend == 2) begin
                    push = 1; f = {RX1_I, RX1_Q, m_hi, m_hq}; m_pend = 0;
                end else begin
                    slip = (m_pend == 1); m_pend = 1; m_hi = RX1_I; m_hq = RX1_Q;
                end
            end else if (rx2_valid) begin
                if (m_pend == 1) begin
                    push = 1; f = {m_hi, m_hq, RX2_I, RX2_Q}; m_pend = 0;
                end else begin
                    slip = (m_pend == 2); m_pend = 2; m_hi = RX2_I; m_hq = RX2_Q;
                end
            end
        end else begin
            m_pend = 0;
        end
        pop_ok = bus.IQ_RX_READ_REQ && (m_q.size() > 0);
        und    = bus.IQ_RX_READ_REQ && (m_q.size() == 0);
        ovr    = push && (m_q.size() == 16) && !bus.IQ_RX_READ_REQ;
        m_rdv  = pop_ok;
        if (pop_ok) m_rd = m_q.pop_front();
        if (push && m_q.size() < 16) m_q.push_back(f);
        m_ovr  = (m_ovr  && !bus.flags_clear) || ovr;
        m_und  = (m_und  && !bus.flags_clear) || und;
        m_slip = (m_slip && !bus.flags_clear) || slip;
        m_e1p  = rx1_enable;
        m_e2p  = rx2_enable;
    endtask

    task automatic step();
        model_update();
        @(posedge clk_in);
        #1;
        rx1_valid = 0; rx2_valid = 0;
        bus.IQ_RX_READ_REQ = 0; bus.flags_clear = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        step();
        reset_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.fill_level !== 5'd0) begin n_bad++; $display("FAIL reset_fill got %0d want 0", bus.fill_level); end
        n_cmp++; if (bus.in_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", bus.in_empty); end
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rdv got %b want 0", bus.rd_valid); end
        n_cmp++; if ({bus.iq_overrun, bus.iq_underrun, bus.pair_slip} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {bus.iq_overrun, bus.iq_underrun, bus.pair_slip}); end
        n_cmp++; if (rd_frame() !== 96'd0) begin n_bad++; $display("FAIL reset_rd got %h want 0", rd_frame()); end
    endtask

    task automatic test_single_channel();
        logic [95:0] exp;
        rx1_enable = 1; rx2_enable = 0;
        step();
        for (int k = 1; k <= 3; k++) begin
            RX1_I = 24'(k); RX1_Q = 24'(24'h0A0000 + k); RX2_I = 24'h555555; RX2_Q = 24'h666666;
            rx1_valid = 1;
            step();
        end
        n_cmp++; if (bus.fill_level !== 5'd3) begin n_bad++; $display("FAIL single_fill got %0d want 3", bus.fill_level); end
        for (int k = 1; k <= 3; k++) begin
            exp = {24'(k), 24'(24'h0A0000 + k), 48'd0};
            bus.IQ_RX_READ_REQ = 1;
            step();
            n_cmp++; if (bus.rd_valid !== 1'b1) begin n_bad++; $display("FAIL single_rdv%0d got %b want 1", k, bus.rd_valid); end
            n_cmp++; if (rd_frame() !== exp) begin n_bad++; $display("FAIL single_pop%0d got %h want %h", k, rd_frame(), exp); end
        end
        step();
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL single_rdv_pulse got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.in_empty !== 1'b1) begin n_bad++; $display("FAIL single_empty got %b want 1", bus.in_empty); end
    endtask

    task automatic test_pairing();
        logic [95:0] exp;
        rx1_enable = 1; rx2_enable = 1;
        step();
        RX1_I = 24'h100000; RX1_Q = 24'h000123; rx1_valid = 1;
        step();
        step();
        n_cmp++; if (bus.fill_level !== 5'd0) begin n_bad++; $display("FAIL pair_held got %0d want 0", bus.fill_level); end
        RX2_I = 24'h200000; RX2_Q = 24'h000456; rx2_valid = 1;
        step();
        n_cmp++; if (bus.fill_level !== 5'd1) begin n_bad++; $display("FAIL pair_fill got %0d want 1", bus.fill_level); end
        n_cmp++; if (bus.pair_slip !== 1'b0) begin n_bad++; $display("FAIL pair_slip got %b want 0", bus.pair_slip); end
        exp = {24'h100000, 24'h000123, 24'h200000, 24'h000456};
        bus.IQ_RX_READ_REQ = 1;
        step();
        n_cmp++; if (rd_frame() !== exp) begin n_bad++; $display("FAIL pair_frame got %h want %h", rd_frame(), exp); end
    endtask

    task automatic test_slip();
        RX1_Q = 24'h0; RX2_Q = 24'h0;
        RX1_I = 24'h11; rx1_valid = 1; step();
        RX1_I = 24'h22; rx1_valid = 1; step();
        RX2_I = 24'h33; rx2_valid = 1; step();
        n_cmp++; if (bus.pair_slip !== 1'b1) begin n_bad++; $display("FAIL slip_flag got %b want 1", bus.pair_slip); end
        bus.IQ_RX_READ_REQ = 1;
        step();
        n_cmp++; if (bus.rd_rx1_i !== 24'h22) begin n_bad++; $display("FAIL slip_rx1i got %h want 000022", bus.rd_rx1_i); end
        n_cmp++; if (bus.rd_rx2_i !== 24'h33) begin n_bad++; $display("FAIL slip_rx2i got %h want 000033", bus.rd_rx2_i); end
        bus.flags_clear = 1;
        step();
        n_cmp++; if (bus.pair_slip !== 1'b0) begin n_bad++; $display("FAIL slip_clear got %b want 0", bus.pair_slip); end
    endtask

    task automatic test_full();
        rx1_enable = 1; rx2_enable = 0;
        step();
        for (int k = 1; k <= 17; k++) begin
            RX1_I = 24'(k); RX1_Q = 24'(k * 3); rx1_valid = 1;
            step();
        end
        n_cmp++; if (bus.fill_level !== 5'd16) begin n_bad++; $display("FAIL full_fill got %0d want 16", bus.fill_level); end
        n_cmp++; if (bus.iq_overrun !== 1'b1) begin n_bad++; $display("FAIL full_ovr got %b want 1", bus.iq_overrun); end
        bus.flags_clear = 1;
        step();
        RX1_I = 24'h0000AA; RX1_Q = 24'h0; rx1_valid = 1; bus.IQ_RX_READ_REQ = 1;
        step();
        n_cmp++; if (bus.fill_level !== 5'd16) begin n_bad++; $display("FAIL full_pushpop_fill got %0d want 16", bus.fill_level); end
        n_cmp++; if (bus.iq_overrun !== 1'b0) begin n_bad++; $display("FAIL full_pushpop_ovr got %b want 0", bus.iq_overrun); end
        n_cmp++; if (bus.rd_rx1_i !== 24'd1) begin n_bad++; $display("FAIL full_first got %h want 000001", bus.rd_rx1_i); end
    endtask

    task automatic test_empty();
        do_reset();
        bus.IQ_RX_READ_REQ = 1;
        step();
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL empty_rdv got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.iq_underrun !== 1'b1) begin n_bad++; $display("FAIL empty_und got %b want 1", bus.iq_underrun); end
        bus.flags_clear = 1;
        step();
        RX1_I = 24'h7; rx1_valid = 1; bus.IQ_RX_READ_REQ = 1;
        step();
        n_cmp++; if (bus.iq_underrun !== 1'b1) begin n_bad++; $display("FAIL empty_pushpop_und got %b want 1", bus.iq_underrun); end
        n_cmp++; if (bus.fill_level !== 5'd1) begin n_bad++; $display("FAIL empty_pushpop_fill got %0d want 1", bus.fill_level); end
    endtask

    task automatic test_reset_mid_pair();
        rx1_enable = 1; rx2_enable = 0;
        step();
        for (int k = 0; k < 4; k++) begin RX1_I = 24'(k); rx1_valid = 1; step(); end
        rx2_enable = 1;
        step();
        RX1_I = 24'h99; rx1_valid = 1; step();
        RX1_I = 24'h98; rx1_valid = 1; step();
        n_cmp++; if (bus.fill_level !== 5'd5 || bus.pair_slip !== 1'b1) begin n_bad++; $display("FAIL midrst_setup got fill=%0d slip=%b want 5/1", bus.fill_level, bus.pair_slip); end
        do_reset();
        n_cmp++; if (bus.fill_level !== 5'd0) begin n_bad++; $display("FAIL midrst_fill got %0d want 0", bus.fill_level); end
        n_cmp++; if (bus.in_empty !== 1'b1) begin n_bad++; $display("FAIL midrst_empty got %b want 1", bus.in_empty); end
        n_cmp++; if ({bus.iq_overrun, bus.iq_underrun, bus.pair_slip} !== 3'b000) begin n_bad++; $display("FAIL midrst_flags got %b want 000", {bus.iq_overrun, bus.iq_underrun, bus.pair_slip}); end
        step();
        RX2_I = 24'h44; rx2_valid = 1;
        step();
        n_cmp++; if (bus.fill_level !== 5'd0) begin n_bad++; $display("FAIL midrst_idle got %0d want 0", bus.fill_level); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 19) == 0) rx1_enable = ~rx1_enable;
            if ($urandom_range(0, 19) == 0) rx2_enable = ~rx2_enable;
            RX1_I = 24'($urandom); RX1_Q = 24'($urandom);
            RX2_I = 24'($urandom); RX2_Q = 24'($urandom);
            rx1_valid = ($urandom_range(0, 2) == 0);
            rx2_valid = ($urandom_range(0, 2) == 0);
            bus.IQ_RX_READ_REQ = ($urandom_range(0, 3) == 0);
            bus.flags_clear = ($urandom_range(0, 24) == 0);
            step();
            n_cmp++;
            if (bus.fill_level !== 5'(m_q.size()) || bus.in_empty !== (m_q.size() == 0) ||
                bus.rd_valid !== m_rdv || bus.iq_overrun !== m_ovr ||
                bus.iq_underrun !== m_und || bus.pair_slip !== m_slip || rd_frame() !== m_rd) begin
                n_bad++;
                $display("FAIL rand_c%0d got fill=%0d rdv=%b ovr=%b und=%b slip=%b rd=%h want fill=%0d rdv=%b ovr=%b und=%b slip=%b rd=%h",
                         c, bus.fill_level, bus.rd_valid, bus.iq_overrun, bus.iq_underrun, bus.pair_slip, rd_frame(),
                         m_q.size(), m_rdv, m_ovr, m_und, m_slip, m_rd);
            end
        end
    endtask

    initial begin
        reset_n = 0;
        rx1_enable = 0; rx2_enable = 0; rx1_valid = 0; rx2_valid = 0;
        RX1_I = '0; RX1_Q = '0; RX2_I = '0; RX2_Q = '0;
        bus.IQ_RX_READ_REQ = 0; bus.flags_clear = 0;
        #1;
        test_reset();
        test_single_channel();
        test_pairing();
        test_slip();
        test_full();
        test_empty();
        test_reset_mid_pair();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_iq_scheduler.md
RX_IQ_SCHEDULER -- requirements
Module: rx_iq_scheduler

Interface
REQ-001 SHALL have: clk_in  input  1  sole clock; all logic on its rising edge.
REQ-002 SHALL have: reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk_in.
REQ-003 SHALL have: rx1_enable, rx2_enable  input  1 each  channel enables, equivalent to the rx1/rx2 bits of the bus interface parameters.
REQ-004 SHALL have: RX1_I, RX1_Q, RX2_I, RX2_Q  input  24 each, signed  decimator outputs.
REQ-005 SHALL have: rx1_valid, rx2_valid  input  1 each  one-cycle sample strobes.
REQ-006 SHALL have: IQ_RX_READ_REQ  input  1  pop request from the bus interface; each high cycle is one request.
REQ-007 SHALL have: rd_rx1_i, rd_rx1_q, rd_rx2_i, rd_rx2_q  output  24 each  popped frame.
REQ-008 SHALL have: rd_valid  output  1  one-cycle pulse marking new rd_* data.
REQ-009 SHALL have: in_empty  output  1  FIFO empty; iq_overrun, iq_underrun, pair_slip  output  1 each  sticky flags.
REQ-010 SHALL have: flags_clear  input  1  clears all sticky flags; fill_level  output  5  frames stored (0..16).

Function
REQ-011 SHALL store frames {RX1_I, RX1_Q, RX2_I, RX2_Q} (96 bits) in a 16-deep FIFO.
REQ-012 SHALL pair samples with FSM states: IDLE, HAVE1, HAVE2.
REQ-013 When rx2_enable=0: each rx1_valid in any state SHALL push a frame with RX2 fields = 0; FSM returns to IDLE.
REQ-014 When rx1_enable=0 and rx2_enable=1: each rx2_valid SHALL push a frame with RX1 fields = 0.
REQ-015 When both are enabled, in IDLE: rx1_valid alone -> latch RX1, go to HAVE1; rx2_valid alone -> latch RX2, go to HAVE2; both together -> push immediately, stay in IDLE.
REQ-016 In HAVE1, rx2_valid SHALL push {held RX1, new RX2} and return to IDLE; HAVE2 is symmetric.
REQ-017 In HAVE1, a repeated rx1_valid without rx2_valid SHALL overwrite the held RX1 and set pair_slip; HAVE2 is symmetric.
REQ-018 In HAVE1/HAVE2, simultaneous rx1_valid and rx2_valid SHALL push {new RX1, new RX2}, drop the held sample, set pair_slip, and go to IDLE.
REQ-019 Any change of rx1_enable or rx2_enable (edge-detected against the previous cycle) SHALL discard the held sample and force IDLE, with no flag set.
REQ-020 Neither enable set: no pushes; FSM held in IDLE.
REQ-021 Push latency: frame visible in fill_level and in_empty one cycle after the completing strobe.
REQ-022 Pop: IQ_RX_READ_REQ=1 with FIFO non-empty -> rd_* updated and rd_valid=1 on the next cycle; rd_* held until the next pop.
REQ-023 Pop on empty: rd_valid stays 0, rd_* unchanged, iq_underrun set.
REQ-024 Push when full with no pop in the same cycle: the frame is dropped and iq_overrun set.
REQ-025 Push and pop in the same cycle when full: both are performed; fill_level is unchanged and no overrun is set.
REQ-026 Push and pop in the same cycle when empty: the pop reports underrun and the push is stored (no bypass).
REQ-027 Read and write pointers are 4 bits and SHALL wrap 15->0; fill_level = count register, saturating at 0..16 by construction.
REQ-028 flags_clear and a new flag event in the same cycle: set wins.

Reset
REQ-029 With reset_n=0 at a clock edge, the following SHALL apply next cycle: FIFO empty (pointers 0, fill_level=0, in_empty=1), FSM=IDLE, held samples 0, rd_*=0, rd_valid=0, all flags 0.
REQ-030 Reset mid-pairing or mid-pop SHALL discard all state; FIFO RAM contents need not be cleared.

Structure
REQ-031 Shared package SHALL hold: IQ_W=24, FIFO_DEPTH=16, FIFO_AW=4, frame width 96, and the pairing state encoding IDLE=0, HAVE1=1, HAVE2=2.
REQ-032 The FIFO SHALL be a sub-module iq_frame_fifo (sync, single clock, full/empty/count outputs); pairing FSM and flags stay in the top module.

Verification
REQ-033 Single channel, rx1 only: 3 rx1_valid with I=0x000001..3 -> 3 frames, RX2 fields 0, fill_level=3, pops return them in order with rd_valid one cycle after each request.
REQ-034 Dual pairing: rx1_valid(I=0x100000), then 2 cycles later rx2_valid(I=0x200000) -> one frame {0x100000, …, 0x200000, …}, pair_slip=0.
REQ-035 Slip: rx1_valid twice (0x11, then 0x22), then rx2_valid(0x33) -> frame RX1_I=0x22, pair_slip=1; flags_clear -> 0.
REQ-036 Full: 17 pushes with no pops -> fill_level=16, iq_overrun=1, first popped frame = push #1; push+pop when full -> level stays 16, no new flag.
REQ-037 Empty pop -> rd_valid=0, iq_underrun=1; push+pop on empty -> underrun=1, fill_level=1.
REQ-038 reset_n=0 for 1 cycle in state HAVE1 with fill_level=5 -> next cycle fill_level=0, in_empty=1, FSM=IDLE, flags=0.
